// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry instruction queue with head decode, valid/stall issue and post-fence drain
module decode_queue #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 4,
    parameter int FENCE_STALL = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [XLEN-1:0]              in_inst,
    input  logic [XLEN-1:0]              in_pc,
    input  logic                         stall,
    input  logic                         flush,
    output logic                         out_valid,
    output logic [XLEN-1:0]              out_inst,
    output logic [XLEN-1:0]              out_pc,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [4:0]                   out_rd,
    output logic [XLEN-1:0]              out_csr_inst,
    output logic                         out_is_load,
    output logic                         out_is_store,
    output logic                         out_is_fence,
    output logic                         out_is_ecall,
    output logic                         out_invalid,
    output logic                         fence_busy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h00000013);

    logic [XLEN-1:0] inst_q [DEPTH];
    logic [XLEN-1:0] pc_q [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop, legal, sfence;
    logic [6:0]      op, f7;
    logic [2:0]      f3;

    // in_ready looks only at count so stall never reaches fetch combinationally
    assign in_ready  = count != CW'(DEPTH);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && !stall;
    assign out_valid = count != '0 && !fence_busy;

    // Idle head is shown as a NOP, which decodes to all-zero fields and flags
    assign out_inst = out_valid ? inst_q[rd_ptr] : NOP;
    assign out_pc   = out_valid ? pc_q[rd_ptr] : '0;
    assign op       = out_inst[6:0];
    assign f3       = out_inst[14:12];
    assign f7       = out_inst[31:25];
    assign sfence   = op == 7'b1110011 && f7 == 7'b0001001 && f3 == 3'b000 && out_inst[11:7] == 5'd0;

    assign out_rs1      = out_inst[19:15];
    assign out_rs2      = op == 7'b1110011 ? 5'd0 : out_inst[24:20];
    assign out_rd       = out_inst[11:7];
    assign out_csr_inst = op == 7'b1110011 ? out_inst : '0;
    assign out_is_load  = op == 7'b0000011 && legal;
    assign out_is_store = op == 7'b0100011 && legal;
    assign out_is_fence = op == 7'b0001111 || sfence;
    assign out_is_ecall = out_inst == XLEN'(32'h00000073);
    assign out_invalid  = !legal;

    // RV32I / Zicsr / Zifencei legality of the head encoding
    always_comb begin
        legal = 1'b0;
        case (op)
            7'b0110011: legal = f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            7'b0010011: legal = f3 == 3'b001 ? f7 == 7'b0 : f3 == 3'b101 ? (f7 == 7'b0 || f7 == 7'b0100000) : 1'b1;
            7'b0000011: legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            7'b0100011: legal = f3 inside {3'b000, 3'b001, 3'b010};
            7'b1100011: legal = !(f3 inside {3'b010, 3'b011});
            7'b1100111: legal = f3 == 3'b000;
            7'b1101111, 7'b0110111, 7'b0010111: legal = 1'b1;
            7'b1110011: legal = !(f3 inside {3'b000, 3'b100}) || out_inst == XLEN'(32'h00000073)
                                || out_inst == XLEN'(32'h30200073) || sfence;
            7'b0001111: legal = f3 == 3'b000 || f3 == 3'b001;
            default:    legal = 1'b0;
        endcase
    end

    // Entry storage needs no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_ptr] <= in_inst;
            pc_q[wr_ptr]   <= in_pc;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    generate
        if (FENCE_STALL > 0) begin : g_fence
            localparam int FW = $clog2(FENCE_STALL+1);
            logic [FW-1:0] fcnt;
            // Drain counter reloads on fence issue and counts down to reopen issue
            always_ff @(posedge clk or posedge rst) begin
                if (rst || flush)
                    fcnt <= '0;
                else
                    fcnt <= pop && out_is_fence ? FW'(FENCE_STALL) : fcnt != '0 ? fcnt - FW'(1) : fcnt;
            end
            assign fence_busy = fcnt != '0;
        end else begin : g_nofence
            assign fence_busy = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: random and directed stimulus against a queue-based reference model
module tb_decode_queue;
    localparam int DEPTH = 4;
    localparam int FS    = 8;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, stall, flush;
    logic [31:0] in_inst, in_pc;
    logic        out_valid, out_is_load, out_is_store, out_is_fence, out_is_ecall, out_invalid, fence_busy;
    logic [31:0] out_inst, out_pc, out_csr_inst;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  count;

    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
    ent_t q[$];
    int   fcnt;
    int   total, bad;
    logic [31:0] pc;

    decode_queue #(.XLEN(32), .DEPTH(DEPTH), .FENCE_STALL(FS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .stall(stall), .flush(flush), .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_csr_inst(out_csr_inst),
        .out_is_load(out_is_load), .out_is_store(out_is_store), .out_is_fence(out_is_fence),
        .out_is_ecall(out_is_ecall), .out_invalid(out_invalid), .fence_busy(fence_busy), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] i);
        logic [2:0] f3 = i[14:12];
        logic [6:0] f7 = i[31:25];
        case (i[6:0])
            7'h33: return f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            7'h13: return f3 == 1 ? f7 == 0 : f3 == 5 ? (f7 == 0 || f7 == 7'h20) : 1'b1;
            7'h03: return f3 inside {0, 1, 2, 4, 5};
            7'h23: return f3 <= 2;
            7'h63: return f3 != 2 && f3 != 3;
            7'h67: return f3 == 0;
            7'h6f, 7'h37, 7'h17: return 1'b1;
            7'h73: return f3 inside {1, 2, 3, 5, 6, 7} || i == 32'h73 || i == 32'h30200073
                          || (f7 == 7'h09 && f3 == 0 && i[11:7] == 0);
            7'h0f: return f3 <= 1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_fence(input logic [31:0] i);
        return i[6:0] == 7'h0f || (i[6:0] == 7'h73 && i[31:25] == 7'h09 && i[14:12] == 0 && i[11:7] == 0);
    endfunction

    task automatic check_outputs();
        bit          v = q.size() != 0 && fcnt == 0;
        logic [31:0] h = 32'h13;
        logic [31:0] p = 0;
        if (v) begin
            h = q[0].inst;
            p = q[0].pc;
        end
        chk("valid", out_valid, v);
        chk("ready", in_ready, q.size() < DEPTH);
        chk("count", count, q.size());
        chk("fbusy", fence_busy, fcnt != 0);
        chk("inst", out_inst, h);
        chk("pc", out_pc, p);
        chk("rs1", out_rs1, h[19:15]);
        chk("rs2", out_rs2, h[6:0] == 7'h73 ? 0 : h[24:20]);
        chk("rd", out_rd, h[11:7]);
        chk("csr", out_csr_inst, h[6:0] == 7'h73 ? h : 0);
        chk("load", out_is_load, h[6:0] == 7'h03 && legal(h));
        chk("store", out_is_store, h[6:0] == 7'h23 && legal(h));
        chk("fence", out_is_fence, is_fence(h));
        chk("ecall", out_is_ecall, h == 32'h73);
        chk("invalid", out_invalid, !legal(h));
    endtask

    task automatic step(input bit iv, input logic [31:0] ins, input bit st, input bit fl);
        bit v, pop, push, isf;
        @(negedge clk);
        check_outputs();
        in_valid = iv;
        in_inst  = ins;
        in_pc    = pc;
        stall    = st;
        flush    = fl;
        @(posedge clk);
        v    = q.size() != 0 && fcnt == 0;
        pop  = v && !st;
        isf  = v && is_fence(q[0].inst);
        push = iv && q.size() < DEPTH && !fl;
        if (fl) begin
            q.delete();
            fcnt = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{ins, pc});
            fcnt = (pop && isf) ? FS : (fcnt > 0 ? fcnt - 1 : 0);
        end
        if (push) pc += 4;
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd1, rs1, 3'b000, rd, 7'h13};
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 13))
            0: begin r[6:0] = 7'h33; r[31:25] = $urandom_range(0, 1) ? 7'h00 : 7'h20; end
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h03;
            3: r[6:0] = 7'h23;
            4: r[6:0] = 7'h63;
            5: r[6:0] = 7'h67;
            6: r[6:0] = 7'h6f;
            7: r[6:0] = 7'h37;
            8: r[6:0] = 7'h17;
            9: r[6:0] = 7'h73;
            10: r[6:0] = 7'h0f;
            11: case ($urandom_range(0, 5))
                    0: r = 32'h00000073;
                    1: r = 32'h30200073;
                    2: r = 32'h0FF0000F;
                    3: r = 32'h12000073;
                    4: r = 32'hFFFFFFFF;
                    default: r = 32'h34011073;
                endcase
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        total = 0; bad = 0; fcnt = 0; pc = 32'h1000;
        rst = 1'b1; in_valid = 0; in_inst = 0; in_pc = 0; stall = 0; flush = 0;
        #1;
        chk("rst_nop", out_inst, 32'h13);
        chk("rst_ready", in_ready, 1);
        check_outputs();
        #2 rst = 1'b0;

        for (int i = 0; i < 3; i++) step(1, addi(5'(i + 5), 5'(i + 1)), 0, 0);
        repeat (2) step(0, 0, 0, 0);

        for (int i = 0; i < 5; i++) step(1, addi(5'(i + 10), 5'(i + 2)), 1, 0);
        repeat (6) step(0, 0, 0, 0);

        step(1, 32'h0FF0000F, 1, 0);
        step(1, 32'h002081B3, 1, 0);
        repeat (12) step(0, 0, 0, 0);

        step(1, 32'h0FF0000F, 1, 0);
        for (int i = 0; i < 3; i++) step(1, addi(5'(i + 1), 5'(i + 3)), 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, addi(5'd7, 5'd7), 0, 1);
        repeat (3) step(0, 0, 0, 0);

        step(1, 32'h34011073, 0, 0);
        step(1, 32'hFFFFFFFF, 0, 0);
        step(1, 32'h00812203, 0, 0);
        step(1, 32'h12000073, 0, 0);
        repeat (12) step(0, 0, 0, 0);

        step(1, 32'h0FF0000F, 1, 0);
        for (int i = 0; i < 3; i++) step(1, addi(5'(i + 20), 5'(i + 1)), 1, 0);
        step(0, 0, 0, 0);
        step(1, addi(5'd9, 5'd9), 1, 0);
        in_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_valid", out_valid, 0);
        chk("arst_nop", out_inst, 32'h13);
        chk("arst_fbusy", fence_busy, 0);
        q.delete();
        fcnt = 0;
        #1 rst = 1'b0;

        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 3) != 0, rnd_inst(), $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
        step(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-register ID stage. A DEPTH-entry instruction queue sits between fetch and the register-read/execute stage.
- Decodes the head entry: rs1/rs2/rd, CSR passthrough, load/store/fence/ecall flags and an illegal-instruction flag.
- Issues the head entry to the backend under a valid/stall handshake.
- Adds a programmable post-fence drain counter, and full/empty back-pressure toward fetch.

Parameters:
- XLEN, 32, instruction and PC width.
- DEPTH, 4, number of queue entries; power of two, at least 2.
- FENCE_STALL, 8, cycles out_valid is held low after a fence issues; 0 disables the drain.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  queue can accept; equals !full
- in_inst  input  XLEN  fetched instruction
- in_pc  input  XLEN  PC of fetched instruction
- stall  input  1  backend cannot take the head this cycle
- flush  input  1  discard all queued entries and any fence drain
- out_valid  output  1  head entry is being offered
- out_inst  output  XLEN  head instruction; 32'h00000013 (NOP) when !out_valid
- out_pc  output  XLEN  head PC; 0 when !out_valid
- out_rs1  output  5  inst[19:15]; 0 when !out_valid
- out_rs2  output  5  inst[24:20]; 0 for SYSTEM opcode or when !out_valid
- out_rd  output  5  inst[11:7]; 0 when !out_valid
- out_csr_inst  output  XLEN  instruction if opcode is 7'b1110011, else 0
- out_is_load  output  1  opcode 0000011 with a legal funct3
- out_is_store  output  1  opcode 0100011 with a legal funct3
- out_is_fence  output  1  opcode 0001111 (FENCE / FENCE.I), or SFENCE.VMA
- out_is_ecall  output  1  instruction == 32'h00000073
- out_invalid  output  1  head is not a legal RV32I/Zicsr/Zifencei encoding; 0 when !out_valid
- fence_busy  output  1  fence drain counter is nonzero
- count  output  $clog2(DEPTH+1)  current number of occupied entries

Behaviour:
- Reset (asynchronous) clears the following; all decoded outputs then show NOP/zero:
  - wr_ptr, rd_ptr and count to 0
  - fence counter to 0
  - out_valid to 0
  - in_ready to 1
- Push: occurs on in_valid && in_ready at the clk edge; {in_inst, in_pc} is written at wr_ptr, which then wraps modulo DEPTH.
- Pop: occurs on out_valid && !stall; rd_ptr then wraps modulo DEPTH.
- Offer condition: out_valid = (count != 0) && !fence_busy.
- Decode is combinational from the registered head entry, so latency from push to earliest out_valid is 1 cycle.
- Simultaneous push and pop: count is unchanged.
- Full queue: in_ready = 0; in_ready depends only on count, not on pop, so there is no comb path from stall to in_ready.
- Flush:
  - Next edge: pointers, count and fence counter go to 0.
  - A push in the same cycle is dropped.
  - A pop in the same cycle is still considered issued by the backend; the backend is responsible for ignoring it.
- Fence drain:
  - When a pop occurs with out_is_fence = 1, the counter loads FENCE_STALL.
  - While nonzero, the counter decrements by 1 each cycle and out_valid = 0.
  - Pushes continue to be accepted during the drain.
  - When the counter reaches 0, the next entry is offered.
  - Counter width is $clog2(FENCE_STALL+1); no counter is instantiated if FENCE_STALL = 0.
- Legality, by opcode:
  - 0110011: funct7 = 0000000 for any funct3; funct7 = 0100000 only for funct3 000 or 101.
  - 0010011: any funct3, except funct3 001 requires funct7 = 0; funct3 101 requires funct7 of 0 or 0100000.
  - 0000011: funct3 in {000, 001, 010, 100, 101}.
  - 0100011: funct3 in {000, 001, 010}.
  - 1100011: funct3 not in {010, 011}.
  - 1100111: funct3 = 000.
  - 1101111, 0110111, 0010111: always legal.
  - 1110011: CSR funct3 in {001, 010, 011, 101, 110, 111}; or exact ECALL 32'h00000073; or MRET 32'h30200073; or SFENCE.VMA (funct7 = 0001001, funct3 = 000, rd = 0).
  - 0001111: funct3 000 or 001.
  - Anything else sets out_invalid.
- Reset asserted mid-drain or with the queue full: the next cycle is fully empty and idle.

Test Plan:
- Push 3 ADDIs on consecutive cycles with stall = 0 -> each out_valid one cycle after its push; out_rd/rs1 match the fields; count peaks at 1.
- Stall held high, push 5 instructions with DEPTH = 4 -> in_ready falls after the 4th; count = 4; 5th not accepted. Release stall -> entries emerge in order, in_ready returns to 1.
- Push FENCE 32'h0FF0000F then ADD -> FENCE issues; fence_busy is high for 8 cycles with out_valid = 0; ADD issues on the 9th cycle after the fence pop.
- Queue holds 3 entries and fence_busy is set; assert flush with in_valid = 1 -> next cycle count = 0, fence_busy = 0, out_valid = 0; the pushed entry is absent.
- Push CSRRW 32'h34011073 -> out_csr_inst equals the instruction, out_rs2 = 0, out_invalid = 0. Push 32'hFFFFFFFF -> out_invalid = 1. Push LW -> out_is_load = 1.
- Assert rst asynchronously while full and mid-drain -> count = 0, in_ready = 1, out_valid = 0, out_inst = 32'h00000013 with no clock edge required.
